// File: rtl/ysyx_22040127_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e  : fetch sequencer states (REQ, WAIT, DROP)
//   NOP_INST     : instruction word shown to decode when nothing is buffered
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fifo_entry_t : one buffered {pc, instruction} pair
package ysyx_22040127_ifu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // may issue a request when credit allows
        WAIT = 2'd1,   // one request in flight, its response will be kept
        DROP = 2'd2    // one request in flight, its response will be thrown away
    } ifu_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

endpackage

// File: rtl/ysyx_22040127_ifu_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop in the same cycle
//   count      : number of valid entries
//   full/empty : occupancy flags
//   head       : oldest entry (contents undefined when empty)
// DEPTH must be a power of two so the pointers wrap on their own.
module ysyx_22040127_ifu_fifo
    import ysyx_22040127_ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fifo_entry_t      push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output fifo_entry_t      head
);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_en  = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset: count alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push_en && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit feeding the single-cycle core.
// Owns the fetch PC, issues aligned requests to instruction memory (at most
// one in flight), buffers responses with their PC, and hands them to decode.
// A redirect flushes the buffer and swallows any stale in-flight response.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   redirect_valid, redirect_pc       : restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req_valid/ready/addr         : request channel to instruction memory
//   imem_resp_valid/data              : in-order response, one per accepted request
//   inst_valid, inst_ready            : handshake toward decode
//   instruction, pc                   : buffer head (nop / 0 when empty)
module ysyx_22040127_ifu
    import ysyx_22040127_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc
);

    localparam int               CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(BUF_DEPTH);

    ifu_state_e       state;
    ifu_state_e       state_n;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_n;
    logic [31:0]      req_pc;
    logic             outstanding;
    logic             req_fire;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fifo_entry_t      fifo_head;
    fifo_entry_t      fifo_wdata;
    logic [CNT_W:0]   credit_used;
    logic             unused_redirect_lsb;

    // Redirect targets are forced to word alignment; the low bits carry nothing.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Exactly one request is in flight whenever the sequencer is not in REQ.
    assign outstanding = (state != REQ);
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding};

    // Credit is judged on this cycle's occupancy; a same-cycle pop does not help.
    assign imem_req_valid = !rst && (state == REQ) && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid  = !rst && !fifo_empty;
    assign instruction = inst_valid ? fifo_head.inst : NOP_INST;
    assign pc          = inst_valid ? fifo_head.pc : 32'h0;
    assign fifo_pop    = inst_valid && inst_ready;

    assign fifo_wdata.pc   = req_pc;
    assign fifo_wdata.inst = imem_resp_data;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        fifo_push  = 1'b0;

        case (state)
            REQ: begin
                if (req_fire) state_n = WAIT;
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    fifo_push = 1'b1;
                    state_n   = REQ;
                end
            end
            DROP: begin
                if (imem_resp_valid) state_n = REQ;
            end
            default: state_n = REQ;
        endcase

        // Wraps modulo 2^32 by construction.
        if (req_fire) fetch_pc_n = fetch_pc + 32'd4;

        // Redirect overrides everything above. A request accepted in this same
        // cycle is already in flight, so its response must be swallowed.
        if (redirect_valid) begin
            fifo_push  = 1'b0;
            fetch_pc_n = {redirect_pc[31:2], 2'b00};
            if (state == REQ) begin
                state_n = req_fire ? DROP : REQ;
            end else begin
                state_n = imem_resp_valid ? REQ : DROP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    // PC travelling with the in-flight request, paired with its response.
    always_ff @(posedge clk) begin
        if (req_fire) req_pc <= fetch_pc;
    end

    ysyx_22040127_ifu_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A response with nothing in flight, or a push into a full buffer, means
    // the memory side or the credit logic is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && !outstanding));
            assert (!(fifo_push && fifo_full));
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
module tb_ysyx_22040127_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] pc;

    ysyx_22040127_ifu #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .instruction     (instruction),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    // Drive settings for the next cycle
    logic        rst_drv      = 1'b1;
    logic        rdy_drv      = 1'b1;
    logic        ir_drv       = 1'b1;
    logic        redir_drv    = 1'b0;
    logic [31:0] redir_pc_drv = 32'h0;
    int          lat_drv      = 1;

    // Observations of the last cycle
    logic        obs_req_valid, obs_inst_valid, obs_fire, obs_pop, obs_resp;
    logic [31:0] obs_addr, obs_pc, obs_inst;
    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];
    int          fire_cyc[$];
    int          pop_cyc[$];
    int          cyc = 0;

    // Memory model: in-order responses after a per-request latency
    typedef struct {
        logic [31:0] addr;
        int          rem;
    } mreq_t;
    mreq_t mq[$];

    // Reference model: next expected request address and next expected
    // delivered PC; both run sequentially and jump to the target on redirect.
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    int          live;
    logic        expect_empty;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        mreq_t       h;
        logic        resp;
        logic [31:0] tgt;
        @(negedge clk);
        rst            = rst_drv;
        imem_req_ready = rdy_drv;
        inst_ready     = ir_drv;
        redirect_valid = redir_drv;
        redirect_pc    = redir_pc_drv;
        resp           = 1'b0;
        imem_resp_data = $urandom;
        if (mq.size() > 0) begin
            if (mq[0].rem == 0) begin
                resp           = 1'b1;
                imem_resp_data = mem_word(mq[0].addr);
            end
        end
        imem_resp_valid = resp;
        #1;
        obs_req_valid  = imem_req_valid;
        obs_addr       = imem_req_addr;
        obs_inst_valid = inst_valid;
        obs_pc         = pc;
        obs_inst       = instruction;
        obs_resp       = resp;
        obs_fire       = imem_req_valid && imem_req_ready;
        obs_pop        = inst_valid && inst_ready;
        tgt            = {redirect_pc[31:2], 2'b00};

        if (rst) begin
            chk("rst_req_valid", 32'(obs_req_valid), 32'd0);
            chk("rst_inst_valid", 32'(obs_inst_valid), 32'd0);
            chk("rst_instruction", obs_inst, NOP);
            chk("rst_pc", obs_pc, 32'h0);
            exp_req      = RST_PC;
            exp_pc       = RST_PC;
            live         = 0;
            expect_empty = 1'b0;
        end else begin
            if (expect_empty) chk("flush_empty", 32'(obs_inst_valid), 32'd0);
            if (obs_req_valid) begin
                chk("req_addr", obs_addr, exp_req);
                chk("credit", 32'(live < DEPTH), 32'd1);
                chk("one_in_flight", 32'(mq.size()), 32'd0);
            end
            if (obs_inst_valid) begin
                chk("head_pc", obs_pc, exp_pc);
                chk("head_inst", obs_inst, mem_word(exp_pc));
            end else begin
                chk("empty_nop", obs_inst, NOP);
                chk("empty_pc", obs_pc, 32'h0);
            end
            if (obs_fire) begin
                exp_req = exp_req + 32'd4;
                live++;
            end
            if (obs_pop) begin
                exp_pc = exp_pc + 32'd4;
                live--;
            end
            expect_empty = redirect_valid;
            if (redirect_valid) begin
                exp_req = tgt;
                exp_pc  = tgt;
                live    = 0;
            end
            if (obs_fire) begin
                fire_log.push_back(obs_addr);
                fire_cyc.push_back(cyc);
            end
            if (obs_pop) begin
                pop_log.push_back(obs_pc);
                pop_cyc.push_back(cyc);
            end
        end

        if (resp) begin
            void'(mq.pop_front());
        end else if (mq.size() > 0) begin
            if (mq[0].rem > 0) begin
                h      = mq[0];
                h.rem  = h.rem - 1;
                mq[0]  = h;
            end
        end
        if (obs_fire) begin
            h.addr = obs_addr;
            h.rem  = lat_drv - 1;
            mq.push_back(h);
        end
        redir_drv = 1'b0;
        cyc++;
    endtask

    task automatic clear_logs();
        fire_log.delete();
        pop_log.delete();
        fire_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        rst_drv   = 1'b1;
        redir_drv = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 20 && mq.size() > 0; i++) tick();
        chk("reset_drain", 32'(mq.size()), 32'd0);
        rst_drv = 1'b0;
        clear_logs();
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && pop_log.size() < n; i++) tick();
        chk(tag, 32'(pop_log.size()), 32'(n));
    endtask

    task automatic wait_fires(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && fire_log.size() < n; i++) tick();
        chk(tag, 32'(fire_log.size()), 32'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;

        // Reset state
        do_reset();
        chk("reset_inst_valid", 32'(obs_inst_valid), 32'd0);
        chk("reset_instruction", obs_inst, NOP);
        chk("reset_pc", obs_pc, 32'h0);

        // 1: sequential fetch, 1-cycle memory, decode always ready
        rdy_drv = 1'b1;
        ir_drv  = 1'b1;
        lat_drv = 1;
        tick();
        chk("t1_first_valid", 32'(obs_req_valid), 32'd1);
        chk("t1_first_addr", obs_addr, RST_PC);
        wait_pops("t1_pops", 3, 30);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req_addr", fire_log[i], RST_PC + 32'(4 * i));
            chk("t1_pop_pc", pop_log[i], RST_PC + 32'(4 * i));
        end
        chk("t1_latency", 32'(pop_cyc[0] - fire_cyc[0]), 32'd2);

        // 2: decode stalled -> credit stops fetch at DEPTH entries
        ir_drv = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("t2_fires", 32'(fire_log.size()), 32'(DEPTH));
        chk("t2_req_idle", 32'(obs_req_valid), 32'd0);
        chk("t2_no_pops", 32'(pop_log.size()), 32'd0);
        ir_drv = 1'b1;
        wait_fires("t2_resume", 3, 30);
        chk("t2_pop0", pop_log[0], RST_PC);
        chk("t2_pop1", pop_log[1], RST_PC + 32'd4);
        chk("t2_resume_addr", fire_log[2], RST_PC + 32'd8);

        // 3: memory not ready -> request held stable
        do_reset();
        rdy_drv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 32'(obs_req_valid), 32'd1);
            chk("t3_hold_addr", obs_addr, RST_PC);
        end
        rdy_drv = 1'b1;
        tick();
        chk("t3_accept_count", 32'(fire_log.size()), 32'd1);
        chk("t3_accept_addr", fire_log[0], RST_PC);

        // 4: redirect while waiting on a 3-cycle response
        do_reset();
        lat_drv = 3;
        tick();
        tick();
        redir_drv    = 1'b1;
        redir_pc_drv = 32'h8000_1002;
        tick();
        clear_logs();
        tick();
        chk("t4_flushed", 32'(obs_inst_valid), 32'd0);
        chk("t4_drop_no_req", 32'(obs_req_valid), 32'd0);
        wait_pops("t4_pops", 1, 30);
        chk("t4_next_req", fire_log[0], 32'h8000_1000);
        chk("t4_first_pc", pop_log[0], 32'h8000_1000);

        // 5: redirect together with a request handshake and a pop
        do_reset();
        lat_drv = 1;
        tick();
        tick();
        redir_drv    = 1'b1;
        redir_pc_drv = 32'h8000_2000;
        tick();
        chk("t5_fire_same_cycle", 32'(obs_fire), 32'd1);
        chk("t5_pop_same_cycle", 32'(obs_pop), 32'd1);
        clear_logs();
        tick();
        chk("t5_flushed", 32'(obs_inst_valid), 32'd0);
        chk("t5_stale_resp", 32'(obs_resp), 32'd1);
        chk("t5_drop_no_req", 32'(obs_req_valid), 32'd0);
        tick();
        chk("t5_req_valid", 32'(obs_req_valid), 32'd1);
        chk("t5_req_addr", obs_addr, 32'h8000_2000);
        wait_pops("t5_pops", 1, 30);
        chk("t5_first_pc", pop_log[0], 32'h8000_2000);

        // 6: reset while a request is in flight; its late response is ignored
        do_reset();
        lat_drv = 3;
        tick();
        tick();
        rst_drv = 1'b1;
        tick();
        chk("t6_rst_req_valid", 32'(obs_req_valid), 32'd0);
        tick();
        chk("t6_next_inst_valid", 32'(obs_inst_valid), 32'd0);
        chk("t6_next_req_valid", 32'(obs_req_valid), 32'd0);
        for (int i = 0; i < 10 && mq.size() > 0; i++) tick();
        chk("t6_stale_drained", 32'(mq.size()), 32'd0);
        rst_drv = 1'b0;
        clear_logs();
        tick();
        chk("t6_req_valid", 32'(obs_req_valid), 32'd1);
        chk("t6_req_addr", obs_addr, RST_PC);
        wait_pops("t6_pops", 1, 30);
        chk("t6_first_pc", pop_log[0], RST_PC);

        // Address wrap-around from the top of the address space
        do_reset();
        lat_drv      = 1;
        redir_drv    = 1'b1;
        redir_pc_drv = 32'hFFFF_FFFE;
        tick();
        clear_logs();
        wait_pops("wrap_pops", 2, 40);
        chk("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
        chk("wrap_pc1", pop_log[1], 32'h0000_0000);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rdy_drv = ($urandom_range(0, 9) < 7);
            ir_drv  = ($urandom_range(0, 3) != 0);
            lat_drv = $urandom_range(1, 4);
            if ($urandom_range(0, 24) == 0) begin
                redir_drv = 1'b1;
                if ($urandom_range(0, 3) == 0) redir_pc_drv = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else                           redir_pc_drv = $urandom;
            end
            tick();
        end
        chk("rand_progress", 32'(pop_log.size() > 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
